// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/data memory port arbiter: FSM states, owner
// encoding and the watchdog counter width helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } arb_owner_t;

    function automatic int arb_cnt_width(input int timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Transaction watchdog: counts REQ/RESP cycles and flags the cycle in which
// the count would reach TIMEOUT_CYCLES so the arbiter can abort.
module mem_arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = arb_cnt_width(TIMEOUT_CYCLES);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && !o_expired) begin
            r_count <= r_count + CW'(1);
        end
    end

    // Fires during the TIMEOUT_CYCLES-th active cycle, so exactly that many
    // REQ/RESP cycles elapse before the abort takes effect.
    assign o_expired = i_en && (r_count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data
// requesters. Define MEM_ARB_RR_EN for round-robin on contention; default is data-first.
//
// Handshake: a requester raises *_req_i with its command and holds it until
// its *_done_o pulse; the memory side holds mem_req_o until mem_gnt_i and then
// returns exactly one mem_rvalid_i, never in the grant cycle itself.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    if_req_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    output logic                    if_done_o,
    output logic [DATA_WIDTH-1:0]   if_rdata_o,
    output logic                    if_stall_o,
    input  logic                    d_req_i,
    input  logic                    d_we_i,
    input  logic [ADDR_WIDTH-1:0]   d_addr_i,
    input  logic [DATA_WIDTH-1:0]   d_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] d_be_i,
    output logic                    d_done_o,
    output logic [DATA_WIDTH-1:0]   d_rdata_o,
    output logic                    d_stall_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    err_o,
    output logic [1:0]              dbg_state_o
);

    localparam int BW = DATA_WIDTH / 8;

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    arb_owner_t              r_owner;
    arb_owner_t              w_winner;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [BW-1:0]           r_be;
    logic                    r_if_done;
    logic                    r_d_done;
    logic [DATA_WIDTH-1:0]   r_if_rdata;
    logic [DATA_WIDTH-1:0]   r_d_rdata;
    logic                    r_err;
    logic                    w_if_elig;
    logic                    w_d_elig;
    logic                    w_grant;
    logic                    w_finish;
    logic                    w_timeout;
    logic                    w_wd_en;
    logic                    w_expired;

    // A requester whose done pulse is this cycle is still holding req; it
    // must not be granted again for the transaction that just finished.
    assign w_if_elig = if_req_i & ~r_if_done;
    assign w_d_elig  = d_req_i & ~r_d_done;

`ifdef MEM_ARB_RR_EN
    arb_owner_t r_last_owner;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last_owner <= OWN_I;
        end else if (w_grant) begin
            r_last_owner <= w_winner;
        end
    end
`endif

    always_comb begin
        w_winner = OWN_I;
        if (w_d_elig) begin
            w_winner = OWN_D;
        end
`ifdef MEM_ARB_RR_EN
        if (w_if_elig && w_d_elig && (r_last_owner == OWN_D)) begin
            w_winner = OWN_I;
        end
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_finish    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_if_elig || w_d_elig) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ARB_REQ;
                end
            end
            ARB_REQ: begin
                if (w_expired) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ARB_IDLE;
                end else if (mem_gnt_i) begin
                    w_state_nxt = ARB_RESP;
                end
            end
            ARB_RESP: begin
                if (mem_rvalid_i) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ARB_IDLE;
                end else if (w_expired) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    assign w_wd_en = (r_state == ARB_REQ) || (r_state == ARB_RESP);

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk     (clk_i),
        .i_rst     (rst_i),
        .i_clr     (w_grant),
        .i_en      (w_wd_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ARB_IDLE;
            r_owner <= OWN_I;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_owner <= w_winner;
                if (w_winner == OWN_D) begin
                    r_we    <= d_we_i;
                    r_addr  <= d_addr_i;
                    r_wdata <= d_wdata_i;
                    r_be    <= d_be_i;
                end else begin
                    r_we    <= 1'b0;
                    r_addr  <= if_addr_i;
                    r_wdata <= '0;
                    r_be    <= '1;
                end
            end
        end
    end

    // Completion path: aborted transactions and stores both return zero data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_if_done  <= 1'b0;
            r_d_done   <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_if_done <= 1'b0;
            r_d_done  <= 1'b0;
            if (w_finish || w_timeout) begin
                if (r_owner == OWN_D) begin
                    r_d_done  <= 1'b1;
                    r_d_rdata <= (w_finish && !r_we) ? mem_rdata_i : '0;
                end else begin
                    r_if_done  <= 1'b1;
                    r_if_rdata <= w_finish ? mem_rdata_i : '0;
                end
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign if_done_o   = r_if_done;
    assign if_rdata_o  = r_if_rdata;
    assign if_stall_o  = if_req_i & ~r_if_done;
    assign d_done_o    = r_d_done;
    assign d_rdata_o   = r_d_rdata;
    assign d_stall_o   = d_req_i & ~r_d_done;
    assign mem_req_o   = (r_state == ARB_REQ);
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign mem_be_o    = r_be;
    assign err_o       = r_err;
    assign dbg_state_o = r_state;

endmodule
